// File: rtl/clock_divider_pkg.sv
// ============================================================================
// Module      : clock_divider_pkg
// Description : Shared channel state encoding, clamp helpers and width helper
//               for the multi-channel clock divider.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

package clock_divider_pkg;

    localparam logic [1:0] c_ST_IDLE  = 2'd0;
    localparam logic [1:0] c_ST_RUN   = 2'd1;
    localparam logic [1:0] c_ST_DRAIN = 2'd2;

    // Address width for a channel index; never narrower than one bit.
    function automatic int clog2_min1(input int value);
        int w;
        w = 0;
        for (int i = 0; i < 31; i++) begin
            if ((1 << i) < value) begin
                w = i + 1;
            end
        end
        return (w < 1) ? 1 : w;
    endfunction

    function automatic logic [31:0] clamp_div(input logic [31:0] n);
        return (n < 32'd2) ? 32'd2 : n;
    endfunction

    // Expects an already-clamped period so that n-1 is at least 1.
    function automatic logic [31:0] clamp_high(input logic [31:0] n, input logic [31:0] h);
        logic [31:0] r;
        if (h == 32'd0) begin
            r = 32'd1;
        end else if (h >= n) begin
            r = n - 32'd1;
        end else begin
            r = h;
        end
        return r;
    endfunction

endpackage

`default_nettype wire

// File: rtl/clock_divider_ch.sv
// ============================================================================
// Module      : clock_divider_ch
// Description : One divider channel: counter, IDLE/RUN/DRAIN state machine,
//               shadow/active period registers and registered outputs.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module clock_divider_ch
    import clock_divider_pkg::*;
#(
    parameter int C_DIV_WIDTH    = 16,
    parameter int C_DEFAULT_DIV  = 16,
    parameter int C_DEFAULT_HIGH = 8
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   i_en,
    input  logic                   i_sync,
    input  logic                   i_cfg_we,
    input  logic [C_DIV_WIDTH-1:0] i_cfg_div,
    input  logic [C_DIV_WIDTH-1:0] i_cfg_high,
    output logic                   o_clk,
    output logic                   o_tick,
    output logic                   o_pending
);

    logic [1:0]             r_state;
    logic [C_DIV_WIDTH-1:0] r_cnt;
    logic [C_DIV_WIDTH-1:0] r_act_div;
    logic [C_DIV_WIDTH-1:0] r_act_high;
    logic [C_DIV_WIDTH-1:0] r_shd_div;
    logic [C_DIV_WIDTH-1:0] r_shd_high;
    logic                   r_pending;
    logic                   r_clk;
    logic                   r_tick;

    logic                   w_running;
    logic                   w_wrap;
    logic                   w_apply;
    logic [C_DIV_WIDTH-1:0] w_new_div;
    logic [C_DIV_WIDTH-1:0] w_new_high;
    logic [C_DIV_WIDTH-1:0] w_cnt_next;

    assign w_running  = (r_state != c_ST_IDLE);
    assign w_wrap     = (r_cnt == r_act_div - 1'b1);
    // Shadow moves to active only where a fresh period begins (or when idle).
    assign w_apply    = r_pending && (!w_running || w_wrap || i_sync);
    assign w_new_div  = C_DIV_WIDTH'(clamp_div(32'(r_shd_div)));
    assign w_new_high = C_DIV_WIDTH'(clamp_high(32'(w_new_div), 32'(r_shd_high)));
    assign w_cnt_next = (i_sync || w_wrap) ? '0 : r_cnt + 1'b1;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state    <= c_ST_IDLE;
            r_cnt      <= '0;
            r_act_div  <= C_DIV_WIDTH'(clamp_div(32'(C_DEFAULT_DIV)));
            r_act_high <= C_DIV_WIDTH'(clamp_high(clamp_div(32'(C_DEFAULT_DIV)), 32'(C_DEFAULT_HIGH)));
            r_shd_div  <= C_DIV_WIDTH'(C_DEFAULT_DIV);
            r_shd_high <= C_DIV_WIDTH'(C_DEFAULT_HIGH);
            r_pending  <= 1'b0;
            r_clk      <= 1'b0;
            r_tick     <= 1'b0;
        end else begin
            if (w_apply) begin
                r_act_div  <= w_new_div;
                r_act_high <= w_new_high;
                r_pending  <= 1'b0;
            end
            if (i_cfg_we) begin
                r_shd_div  <= i_cfg_div;
                r_shd_high <= i_cfg_high;
                r_pending  <= 1'b1;
            end

            case (r_state)
                c_ST_IDLE: begin
                    r_cnt <= '0;
                    if (i_en) begin
                        r_state <= c_ST_RUN;
                        r_clk   <= 1'b1;
                        r_tick  <= 1'b1;
                    end else begin
                        r_clk   <= 1'b0;
                        r_tick  <= 1'b0;
                    end
                end
                c_ST_RUN, c_ST_DRAIN: begin
                    if (!i_en && w_wrap && !i_sync) begin
                        r_state <= c_ST_IDLE;
                        r_cnt   <= '0;
                        r_clk   <= 1'b0;
                        r_tick  <= 1'b0;
                    end else begin
                        r_state <= i_en ? c_ST_RUN : c_ST_DRAIN;
                        r_cnt   <= w_cnt_next;
                        r_clk   <= (w_cnt_next < r_act_high);
                        r_tick  <= (w_cnt_next == '0);
                    end
                end
                default: begin
                    r_state <= c_ST_IDLE;
                    r_cnt   <= '0;
                    r_clk   <= 1'b0;
                    r_tick  <= 1'b0;
                end
            endcase
        end
    end

    assign o_clk     = r_clk;
    assign o_tick    = r_tick;
    assign o_pending = r_pending;

endmodule

`default_nettype wire

// File: rtl/clock_divider_multi.sv
// ============================================================================
// Module      : clock_divider_multi
// Description : Multi-channel programmable clock divider with glitch-free,
//               period-boundary configuration updates and in-phase restart.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module clock_divider_multi
    import clock_divider_pkg::*;
#(
    parameter int C_NUM_CH       = 4,
    parameter int C_DIV_WIDTH    = 16,
    parameter int C_DEFAULT_DIV  = 16,
    parameter int C_DEFAULT_HIGH = 8
) (
    input  logic                            aclk,
    input  logic                            areset,
    input  logic [C_NUM_CH-1:0]             ch_en,
    input  logic                            sync_start,
    input  logic                            cfg_valid,
    output logic                            cfg_ready,
    input  logic [clog2_min1(C_NUM_CH)-1:0] cfg_ch,
    input  logic [C_DIV_WIDTH-1:0]          cfg_div,
    input  logic [C_DIV_WIDTH-1:0]          cfg_high,
    output logic [C_NUM_CH-1:0]             out_clk,
    output logic [C_NUM_CH-1:0]             out_tick,
    output logic [C_NUM_CH-1:0]             cfg_pending
);

    localparam int c_CH_W    = clog2_min1(C_NUM_CH);
    localparam int c_CH_SPAN = 1 << c_CH_W;

    logic [C_NUM_CH-1:0]  w_clk;
    logic [C_NUM_CH-1:0]  w_tick;
    logic [C_NUM_CH-1:0]  w_pending;
    logic [c_CH_SPAN-1:0] w_pend_ext;
    logic                 w_accept;

    // Unpopulated channel indices read as not pending, so writes to them drain harmlessly.
    assign w_pend_ext = c_CH_SPAN'(w_pending);
    assign cfg_ready  = ~w_pend_ext[cfg_ch];
    assign w_accept   = cfg_valid & cfg_ready;

    generate
        for (genvar i = 0; i < C_NUM_CH; i++) begin : g_ch
            clock_divider_ch #(
                .C_DIV_WIDTH    (C_DIV_WIDTH),
                .C_DEFAULT_DIV  (C_DEFAULT_DIV),
                .C_DEFAULT_HIGH (C_DEFAULT_HIGH)
            ) u_ch (
                .clk        (aclk),
                .rst        (areset),
                .i_en       (ch_en[i]),
                .i_sync     (sync_start),
                .i_cfg_we   (w_accept && (cfg_ch == c_CH_W'(i))),
                .i_cfg_div  (cfg_div),
                .i_cfg_high (cfg_high),
                .o_clk      (w_clk[i]),
                .o_tick     (w_tick[i]),
                .o_pending  (w_pending[i])
            );
        end
    endgenerate

    assign out_clk     = w_clk;
    assign out_tick    = w_tick;
    assign cfg_pending = w_pending;

endmodule

`default_nettype wire

// File: tb/tb_clock_divider_multi.sv
// ============================================================================
// Module      : tb_clock_divider_multi
// Description : Directed self-checking bench for clock_divider_multi.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_clock_divider_multi;

    logic        aclk;
    logic        areset;
    logic [3:0]  ch_en;
    logic        sync_start;
    logic        cfg_valid;
    logic        cfg_ready;
    logic [1:0]  cfg_ch;
    logic [15:0] cfg_div;
    logic [15:0] cfg_high;
    logic [3:0]  out_clk;
    logic [3:0]  out_tick;
    logic [3:0]  cfg_pending;

    int checks;
    int failures;
    int r_highs;
    int r_ticks;

    clock_divider_multi dut (
        .aclk        (aclk),
        .areset      (areset),
        .ch_en       (ch_en),
        .sync_start  (sync_start),
        .cfg_valid   (cfg_valid),
        .cfg_ready   (cfg_ready),
        .cfg_ch      (cfg_ch),
        .cfg_div     (cfg_div),
        .cfg_high    (cfg_high),
        .out_clk     (out_clk),
        .out_tick    (out_tick),
        .cfg_pending (cfg_pending)
    );

    initial aclk = 1'b0;
    always #5 aclk = ~aclk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    task automatic step(input int n);
        repeat (n) @(negedge aclk);
    endtask

    task automatic capture(input int ch, input int n, output int highs, output int ticks);
        highs = 0;
        ticks = 0;
        for (int i = 0; i < n; i++) begin
            @(negedge aclk);
            highs += int'(out_clk[ch]);
            ticks += int'(out_tick[ch]);
        end
    endtask

    task automatic write_cfg(input logic [1:0] ch, input logic [15:0] div, input logic [15:0] high);
        cfg_valid = 1'b1;
        cfg_ch    = ch;
        cfg_div   = div;
        cfg_high  = high;
        step(1);
        cfg_valid = 1'b0;
    endtask

    task automatic wait_tick(input int ch, input int budget);
        int n;
        n = 0;
        do begin
            step(1);
            n++;
        end while (!out_tick[ch] && n < budget);
        chk("wait_tick", 32'(out_tick[ch]), 32'd1);
    endtask

    task automatic wait_pending_clr(input logic [3:0] mask, input int budget);
        int n;
        n = 0;
        do begin
            step(1);
            n++;
        end while (((cfg_pending & mask) != 4'd0) && n < budget);
        chk("wait_pending_clr", 32'(cfg_pending & mask), 32'd0);
    endtask

    initial begin
        checks     = 0;
        failures   = 0;
        areset     = 1'b1;
        ch_en      = 4'b0000;
        sync_start = 1'b0;
        cfg_valid  = 1'b0;
        cfg_ch     = 2'd0;
        cfg_div    = 16'd0;
        cfg_high   = 16'd0;

        // Reset state
        step(3);
        chk("rst_out_clk", 32'(out_clk), 32'd0);
        chk("rst_out_tick", 32'(out_tick), 32'd0);
        chk("rst_pending", 32'(cfg_pending), 32'd0);
        #1;
        chk("rst_ready", 32'(cfg_ready), 32'd1);

        // Default 16/8 on ch0, first rise on the enable edge
        areset = 1'b0;
        ch_en  = 4'b0001;
        step(1);
        chk("def_first_clk", 32'(out_clk[0]), 32'd1);
        chk("def_first_tick", 32'(out_tick[0]), 32'd1);
        capture(0, 16, r_highs, r_ticks);
        chk("def_highs", r_highs, 8);
        chk("def_ticks", r_ticks, 1);
        chk("def_tick_at_16", 32'(out_tick[0]), 32'd1);

        // Odd divide 5/2 on idle ch1
        cfg_valid = 1'b1;
        cfg_ch    = 2'd1;
        cfg_div   = 16'd5;
        cfg_high  = 16'd2;
        #1;
        chk("odd_ready", 32'(cfg_ready), 32'd1);
        step(1);
        cfg_valid = 1'b0;
        #1;
        chk("odd_pending", 32'(cfg_pending[1]), 32'd1);
        chk("odd_ready_low", 32'(cfg_ready), 32'd0);
        step(1);
        chk("odd_idle_apply", 32'(cfg_pending[1]), 32'd0);
        ch_en[1] = 1'b1;
        step(1);
        chk("odd_start_clk", 32'(out_clk[1]), 32'd1);
        capture(1, 5, r_highs, r_ticks);
        chk("odd_highs", r_highs, 2);
        chk("odd_ticks", r_ticks, 1);
        capture(1, 10, r_highs, r_ticks);
        chk("odd_highs2", r_highs, 4);
        chk("odd_ticks2", r_ticks, 2);

        // Clamp 1/0 -> 2/1 on ch2
        write_cfg(2'd2, 16'd1, 16'd0);
        step(1);
        ch_en[2] = 1'b1;
        step(1);
        chk("clampA_clk0", 32'(out_clk[2]), 32'd1);
        step(1);
        chk("clampA_clk1", 32'(out_clk[2]), 32'd0);
        chk("clampA_tick1", 32'(out_tick[2]), 32'd0);
        step(1);
        chk("clampA_tick2", 32'(out_tick[2]), 32'd1);
        capture(2, 4, r_highs, r_ticks);
        chk("clampA_highs", r_highs, 2);
        chk("clampA_ticks", r_ticks, 2);

        // Clamp 4/9 -> 4/3 on ch3
        write_cfg(2'd3, 16'd4, 16'd9);
        step(1);
        ch_en[3] = 1'b1;
        step(1);
        capture(3, 8, r_highs, r_ticks);
        chk("clampB_highs", r_highs, 6);
        chk("clampB_ticks", r_ticks, 2);

        // Boundary update on ch0: 10/3 written at cnt=4 of a 16 period
        wait_tick(0, 20);
        step(4);
        cfg_valid = 1'b1;
        cfg_ch    = 2'd0;
        cfg_div   = 16'd10;
        cfg_high  = 16'd3;
        #1;
        chk("bnd_ready", 32'(cfg_ready), 32'd1);
        step(1);
        cfg_div  = 16'd7;
        cfg_high = 16'd1;
        #1;
        chk("bnd_stall_ready", 32'(cfg_ready), 32'd0);
        chk("bnd_pending", 32'(cfg_pending[0]), 32'd1);
        step(4);
        chk("bnd_pending_mid", 32'(cfg_pending[0]), 32'd1);
        chk("bnd_ready_mid", 32'(cfg_ready), 32'd0);
        cfg_valid = 1'b0;
        step(6);
        chk("bnd_no_early_tick", 32'(out_tick[0]), 32'd0);
        chk("bnd_pending_last", 32'(cfg_pending[0]), 32'd1);
        step(1);
        chk("bnd_wrap_tick", 32'(out_tick[0]), 32'd1);
        chk("bnd_pending_clr", 32'(cfg_pending[0]), 32'd0);
        capture(0, 10, r_highs, r_ticks);
        chk("bnd_new_highs", r_highs, 3);
        chk("bnd_new_ticks", r_ticks, 1);

        // Drain on ch2 with 8/6, ch_en dropped at cnt=3
        write_cfg(2'd2, 16'd8, 16'd6);
        wait_pending_clr(4'b0100, 10);
        chk("drn_apply_tick", 32'(out_tick[2]), 32'd1);
        step(3);
        ch_en[2] = 1'b0;
        capture(2, 4, r_highs, r_ticks);
        chk("drn_rest_highs", r_highs, 2);
        chk("drn_rest_ticks", r_ticks, 0);
        capture(2, 10, r_highs, r_ticks);
        chk("drn_idle_highs", r_highs, 0);
        chk("drn_idle_ticks", r_ticks, 0);

        // Re-enable during drain keeps phase
        ch_en[2] = 1'b1;
        step(1);
        chk("drn_restart_tick", 32'(out_tick[2]), 32'd1);
        step(3);
        ch_en[2] = 1'b0;
        step(2);
        ch_en[2] = 1'b1;
        capture(2, 3, r_highs, r_ticks);
        chk("drn_reen_highs", r_highs, 1);
        chk("drn_reen_ticks", r_ticks, 1);
        chk("drn_reen_phase", 32'(out_tick[2]), 32'd1);

        // sync_start: ch0 6/3, ch1 9/4, ch2 idle
        ch_en[2] = 1'b0;
        write_cfg(2'd0, 16'd6, 16'd3);
        write_cfg(2'd1, 16'd9, 16'd4);
        wait_pending_clr(4'b0011, 40);
        step(10);
        chk("sync_ch2_idle", 32'(out_clk[2]), 32'd0);
        step(2);
        sync_start = 1'b1;
        step(1);
        sync_start = 1'b0;
        chk("sync_ticks", 32'(out_tick), 32'b1011);
        chk("sync_clks", 32'(out_clk), 32'b1011);
        step(6);
        chk("sync_ch0_period", 32'(out_tick[0]), 32'd1);
        chk("sync_ch1_mid", 32'(out_tick[1]), 32'd0);
        step(3);
        chk("sync_ch1_period", 32'(out_tick[1]), 32'd1);

        // Reset mid-run with a pending write
        write_cfg(2'd1, 16'd3, 16'd1);
        chk("mrst_pre_pending", 32'(cfg_pending[1]), 32'd1);
        chk("mrst_pre_high", 32'(out_clk[1]), 32'd1);
        areset = 1'b1;
        step(1);
        chk("mrst_clk", 32'(out_clk), 32'd0);
        chk("mrst_tick", 32'(out_tick), 32'd0);
        chk("mrst_pending", 32'(cfg_pending), 32'd0);
        areset = 1'b0;
        ch_en  = 4'b0010;
        step(1);
        chk("mrst_restart_clk", 32'(out_clk[1]), 32'd1);
        capture(1, 16, r_highs, r_ticks);
        chk("mrst_def_highs", r_highs, 8);
        chk("mrst_def_ticks", r_ticks, 1);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

`default_nettype wire

// File: doc/clock_divider_multi.md
Name: clock_divider_multi

Overview:
- Multi-channel programmable clock-enable/clock divider.
- Each channel derives a registered divided clock from aclk with a runtime period, runtime duty cycle and per-channel enable, plus a one-cycle tick at each divided rising edge.
- Configuration changes take effect only at period boundaries, so outputs are glitch-free.
- Feeds peripheral baud/sample timing and low-speed interface clocks in the fabric.

Parameters:
- C_NUM_CH, 4, number of independent channels (1..16).
- C_DIV_WIDTH, 16, width of period and high-time fields.
- C_DEFAULT_DIV, 16, period in aclk cycles after reset (>=2).
- C_DEFAULT_HIGH, 8, high-phase length in aclk cycles after reset.

Ports:
- aclk  in  1  clock.
- areset  in  1  synchronous active-high reset.
- ch_en  in  C_NUM_CH  per-channel run enable (level).
- sync_start  in  1  pulse: restart all running channels in phase.
- cfg_valid  in  1  config write request.
- cfg_ready  out  1  config write accepted this cycle when high with cfg_valid.
- cfg_ch  in  clog2(C_NUM_CH) (min 1)  target channel.
- cfg_div  in  C_DIV_WIDTH  new period N.
- cfg_high  in  C_DIV_WIDTH  new high time H.
- out_clk  out  C_NUM_CH  divided clocks, registered.
- out_tick  out  C_NUM_CH  one-aclk pulse coinciding with each out_clk rise.
- cfg_pending  out  C_NUM_CH  shadow config waiting to be applied.

Behaviour:
- Reset (sync, areset=1 at posedge): out_clk=0, out_tick=0, cnt=0, active=0, pending=0, active and shadow N/H = C_DEFAULT_DIV/C_DEFAULT_HIGH. areset overrides all other inputs.
- Clamping, applied when config is loaded into active: N<2 -> N=2; H=0 -> H=1; H>=N -> H=N-1.
- Channel states:
  - IDLE: out_clk=0, cnt=0.
  - RUN: counter cnt runs 0..N-1 and wraps.
  - DRAIN: entered when ch_en falls; the current period completes.
- IDLE->RUN: at the edge ch_en is sampled 1. cnt<=0, out_clk<=1, out_tick<=1 on that same edge.
- RUN: each edge, cnt_next = (cnt==N-1) ? 0 : cnt+1. out_clk <= (cnt_next < H). out_tick <= (cnt_next==0).
- RUN->DRAIN on ch_en=0. DRAIN continues counting. At cnt==N-1 the channel goes to IDLE, out_clk stays 0, no tick. ch_en re-asserted during DRAIN returns the channel to RUN without a phase break.
- Output period is exactly N aclk cycles. High phase is exactly H cycles. Odd N is supported, e.g. N=5/H=2 gives 2 high, 3 low.
- Config handshake:
  - cfg_ready = ~pending[cfg_ch].
  - On accept, the shadow for cfg_ch takes the new N/H and pending[cfg_ch]<=1.
  - Values are not clamped until they are applied.
- Apply point: shadow->active when cnt==N-1 in RUN/DRAIN, or immediately (next edge) in IDLE. pending clears on the same edge. The new period starts at the wrap.
- Accept and apply in the same cycle is impossible by construction, because cfg_ready is low while pending.
- sync_start:
  - Every channel in RUN/DRAIN is forced to cnt_next=0 with a tick. Pending config is applied at that edge.
  - IDLE channels are unaffected.
  - If ch_en rises on the same edge, that channel starts in phase with the others.
- Counters are C_DIV_WIDTH bits and never exceed N-1. No overflow path.
- Reset mid-period truncates immediately: out_clk=0 on the next edge, no partial-phase protection.

Decomposition:
- Package clock_divider_pkg holds:
  - clamp function for N/H;
  - channel state encoding (IDLE, RUN, DRAIN);
  - the clog2 helper used for the cfg_ch width.
- One sub-module: clock_divider_ch, holding one channel's counter, state machine, shadow/active registers and output flops.
- The top level instantiates C_NUM_CH copies with a generate loop and decodes cfg_ch, cfg_ready and sync_start.

Test Plan:
- Reset defaults: release areset, ch_en=1 -> out_clk[0] period 16, high 8, tick every 16 cycles; first rise on the enable edge.
- Odd divide and clamps: N=5/H=2 -> 2 high/3 low. N=1/H=0 -> N=2/H=1. N=4/H=9 -> H=3.
- Boundary update: write N=10/H=3 mid-period while N=16 -> current period finishes at 16 cycles, next is 10/3. cfg_ready low and cfg_pending high until the wrap. A second write during pending is stalled.
- Drain: drop ch_en at cnt=3 of N=8 -> remaining cycles complete, then out_clk is held 0 with no extra tick. Re-enable during drain -> no phase break.
- sync_start: ch0 N=6, ch1 N=9 running at arbitrary phases, pulse sync_start -> both tick on the same edge; an IDLE ch2 stays low.
- Reset mid-run: areset during a high phase -> out_clk=0, cfg_pending=0 next edge. Shadow N/H return to the parameter defaults.
